// File: rtl/sysarray_pkg.sv
// sysarray_pkg: shared defaults, vector type and FIFO sizing helper for the systolic array drain
package sysarray_pkg;
  localparam int N = 4;
  typedef real real_vec_t [N];
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/sysarray_delay_line.sv
// sysarray_delay_line: D-stage real-valued delay; D=0 is a plain wire
module sysarray_delay_line #(
  parameter int D = 1
) (
  input  logic clk,
  input  logic rst,
  input  real  d,
  output real  q
);
  if (D == 0) begin : g_wire
    logic unused_ok;
    assign unused_ok = clk ^ rst;
    assign q = d;
  end else begin : g_reg
    real r [D];
    // shift the sample one stage per clock; cleared on reset so no stale data emerges
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < D; i++) r[i] <= 0.0;
      end else begin
        r[0] <= d;
        for (int i = 1; i < D; i++) r[i] <= r[i-1];
      end
    end
    assign q = r[D-1];
  end
endmodule

// File: rtl/sysarray_deskew_collector.sv
// sysarray_deskew_collector: removes output wavefront skew and queues whole vectors for the host
module sysarray_deskew_collector
  import sysarray_pkg::*;
#(
  parameter int N         = sysarray_pkg::N,
  parameter int DEPTH     = 8,
  parameter int AF_MARGIN = N
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       in_valid,
  input  real                        in_data [N],
  output logic                       out_valid,
  input  logic                       out_ready,
  output real                        out_data [N],
  output logic [cnt_w(DEPTH)-1:0]    count,
  output logic                       almost_full,
  output logic                       overflow
);
  localparam int CW = cnt_w(DEPTH);
  localparam int AW = $clog2(DEPTH);
  localparam int VW = N - 1;
  real aligned [N];
  real mem [DEPTH][N];
  logic [VW-1:0] vp;
  logic [AW-1:0] wptr, rptr;
  logic av, full, rd, wr;
  genvar c;
  for (c = 0; c < N; c++) begin : g_col
    sysarray_delay_line #(.D(N - 1 - c)) u_dl (
      .clk (clk),
      .rst (rst),
      .d   (in_data[c]),
      .q   (aligned[c])
    );
  end
  // handshake decode; full/empty come from the count so there is no pointer ambiguity
  always_comb begin
    av          = vp[VW-1];
    full        = count == CW'(DEPTH);
    out_valid   = count != '0;
    almost_full = count >= CW'(DEPTH - AF_MARGIN);
    rd          = out_valid & out_ready;
    wr          = av & (~full | rd) & ~clear;
    for (int j = 0; j < N; j++) out_data[j] = mem[rptr][j];
  end
  // valid pipe, FIFO storage, pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vp       <= '0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        for (int j = 0; j < N; j++) mem[i][j] <= 0.0;
    end else if (clear) begin
      vp       <= '0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      vp <= VW'({vp, in_valid});
      if (wr) begin
        for (int j = 0; j < N; j++) mem[wptr][j] <= aligned[j];
        wptr <= wptr + AW'(1);
      end
      if (rd) rptr <= rptr + AW'(1);
      count <= count + CW'(wr) - CW'(rd);
      if (av & full & ~rd) overflow <= 1'b1;
    end
  end
endmodule

// File: doc/sysarray_deskew_collector.md
# sysarray_deskew_collector

Output-side collector for the systolic array. It captures the diagonally skewed result wavefront leaving the array's last row of PEs and re-aligns it into whole N-element vectors. It buffers those vectors in a small FIFO and hands them to the host with a valid/ready handshake. It is the drain counterpart of the pipeline-register stages that carry x/c/s through the array: those stages add skew moving inward, and this block removes it moving outward.

## Interface
Parameters:
- N, 4: array width (columns / vector length), ≥ 2
- DEPTH, 8: FIFO depth in vectors, power of two, ≥ 2
- AF_MARGIN, N: almost_full asserts when count ≥ DEPTH − AF_MARGIN

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous flush of delay lines, FIFO, overflow
- in_valid  in  1  marks column 0 of a vector in this cycle
- in_data  in  real[N]  array boundary outputs; element j of a vector arrives j cycles after its in_valid
- out_valid  out  1  FIFO head holds a vector
- out_ready  in  1  consumer accepts head this cycle
- out_data  out  real[N]  aligned vector at FIFO head
- count  out  $clog2(DEPTH+1)  vectors stored
- almost_full  out  1  throttle hint to the feeder
- overflow  out  1  sticky; a vector was dropped

## Operation
- Deskew: column j passes through N−1−j real registers (column N−1 is a wire). in_valid passes through an N−1-stage valid pipe. The aligned vector and valid appear together N−1 cycles after in_valid.
- Stream rate is one vector per cycle. Vectors may be back-to-back. The array cannot stall, so the deskew path never back-pressures.
- FIFO write: aligned valid and (not full, or a read in the same cycle).
- FIFO read: out_valid and out_ready.
- Aligned valid while full with no read drops the vector and sets overflow. overflow holds until clear or reset.
- Simultaneous read and write when full: both happen, count unchanged, no overflow.
- Simultaneous read and write when empty: only the write occurs; there is no bypass.
- Pointers wrap modulo DEPTH. A full/empty ambiguity is not allowed: use the count or an extra pointer bit.
- clear: valid pipe, count, pointers and overflow go to 0 on the next edge. in_valid in the clear cycle is ignored. Real data registers may keep stale values.
- Reset (rst low): all registers go to 0 immediately. Outputs: out_valid=0, out_data all 0.0, count=0, almost_full=0, overflow=0. In-flight partial vectors are discarded and never emerge after release.

## Timing
- in_valid sampled in cycle 0; in_data[j] sampled in cycle j.
- Aligned vector written at the end of cycle N−1.
- out_valid high in cycle N when the FIFO was empty. End-to-end latency is N cycles.
- count, almost_full and out_valid are registered and update the cycle after the write or read.
- out_data is the head entry. It must be stable while out_valid=1 and out_ready=0.
- AF_MARGIN=N covers the vectors still inside the deskew pipe when the feeder reacts.

## Structure
- Package sysarray_pkg:
  - default N
  - typedef of a real vector, real_vec_t [N]
  - FIFO count width helper function
- Sub-module sysarray_delay_line (parameter D, real in/out, D=0 gives a wire) is instantiated per column via generate.
- FIFO storage and pointers are inline. They are not reused elsewhere.

## Test plan
- N=4, DEPTH=8, single vector: in_valid in cycle 0, in_data[j]=1.0+j in cycle j, out_ready=1. Required: out_valid only in cycle 4, out_data={1.0,2.0,3.0,4.0}.
- Stream 8 back-to-back vectors, vector k element j = 10k+j, out_ready=1. Required: out_valid in cycles 4–11, in order, count ≤ 1.
- Backpressure: out_ready=0, push 12 vectors. Required:
  - almost_full rises when count reaches 4
  - count saturates at 8
  - overflow set on the 9th aligned write
  - draining yields exactly vectors 1–8
- Full plus simultaneous read/write: at count=8, out_ready=1 while a vector aligns. Required: count stays 8, overflow stays 0, order preserved.
- Reset mid-vector: drop rst in cycle 2 of a vector. Required: all outputs 0 immediately; after release no out_valid ever appears for that vector.
- Clear: assert clear with 3 stored vectors and 1 in flight. Required: next cycle count=0, out_valid=0, overflow=0, and the in-flight vector never appears.
